// File: rtl/wave_stream_pkg.sv
// Shared constants for the scrolling wave generator: screen geometry and FSM encodings.
// No logic, so no latency and no backpressure.
package wave_stream_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int ADDR_W        = $clog2(SCREEN_WIDTH);

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  typedef logic [9:0] height_t;

endpackage

// File: rtl/wave_stream_if.sv
// Bus between the frequency source, video timing and the wave generator.
// Pure wiring; the video side free-runs, so there is no backpressure.
interface wave_stream_if;
  import wave_stream_pkg::*;

  logic [10:0] frequency;
  logic        new_f;
  logic        vsync;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  height_t     wave_prof;
  logic        wave_clk;
  logic [10:0] p_offset;
  logic        wave_ready;

  modport master (
    output frequency, new_f, vsync, hcount, vcount,
    input  wave_prof, wave_clk, p_offset, wave_ready
  );

  modport slave (
    input  frequency, new_f, vsync, hcount, vcount,
    output wave_prof, wave_clk, p_offset, wave_ready
  );

endinterface

// File: rtl/wave_stream_sine_lut.sv
// Quarter-wave sine ROM, 64 entries of round(255*sin(i*pi/128)); registered output.
// Latency 1 cycle, no backpressure.
module sine_lut (
  input  logic       clock,
  input  logic [5:0] idx,
  output logic [7:0] val
);

  logic [7:0] rom;

  always_comb begin
    rom = 8'd0;
    case (idx)
      6'd0:  rom = 8'd0;   6'd1:  rom = 8'd6;   6'd2:  rom = 8'd13;  6'd3:  rom = 8'd19;
      6'd4:  rom = 8'd25;  6'd5:  rom = 8'd31;  6'd6:  rom = 8'd37;  6'd7:  rom = 8'd44;
      6'd8:  rom = 8'd50;  6'd9:  rom = 8'd56;  6'd10: rom = 8'd62;  6'd11: rom = 8'd68;
      6'd12: rom = 8'd74;  6'd13: rom = 8'd80;  6'd14: rom = 8'd86;  6'd15: rom = 8'd92;
      6'd16: rom = 8'd98;  6'd17: rom = 8'd103; 6'd18: rom = 8'd109; 6'd19: rom = 8'd115;
      6'd20: rom = 8'd120; 6'd21: rom = 8'd126; 6'd22: rom = 8'd131; 6'd23: rom = 8'd136;
      6'd24: rom = 8'd142; 6'd25: rom = 8'd147; 6'd26: rom = 8'd152; 6'd27: rom = 8'd157;
      6'd28: rom = 8'd162; 6'd29: rom = 8'd167; 6'd30: rom = 8'd171; 6'd31: rom = 8'd176;
      6'd32: rom = 8'd180; 6'd33: rom = 8'd185; 6'd34: rom = 8'd189; 6'd35: rom = 8'd193;
      6'd36: rom = 8'd197; 6'd37: rom = 8'd201; 6'd38: rom = 8'd205; 6'd39: rom = 8'd208;
      6'd40: rom = 8'd212; 6'd41: rom = 8'd215; 6'd42: rom = 8'd219; 6'd43: rom = 8'd222;
      6'd44: rom = 8'd225; 6'd45: rom = 8'd228; 6'd46: rom = 8'd231; 6'd47: rom = 8'd233;
      6'd48: rom = 8'd236; 6'd49: rom = 8'd238; 6'd50: rom = 8'd240; 6'd51: rom = 8'd242;
      6'd52: rom = 8'd244; 6'd53: rom = 8'd246; 6'd54: rom = 8'd247; 6'd55: rom = 8'd249;
      6'd56: rom = 8'd250; 6'd57: rom = 8'd251; 6'd58: rom = 8'd252; 6'd59: rom = 8'd253;
      6'd60: rom = 8'd254; 6'd61: rom = 8'd254; 6'd62: rom = 8'd255; 6'd63: rom = 8'd255;
      default: rom = 8'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    val <= rom;
  end

endmodule

// File: rtl/wave_stream.sv
// Scrolling sine surface: ring buffer of column heights, SCROLL new columns per vsync.
// Read path 2 cycles from hcount to wave_prof; video timing free-runs, no backpressure.
module wave_stream
  import wave_stream_pkg::*;
#(
  parameter int SCROLL   = 4,
  parameter int BASELINE = 384
) (
  input  logic         clock,
  input  logic         reset,
  wave_stream_if.slave bus
);

  localparam logic [ADDR_W-1:0] SCROLL_A  = ADDR_W'(SCROLL);
  localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(SCREEN_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(SCROLL - 1);
  localparam height_t           BASE_H    = height_t'(BASELINE);

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt, base, waddr, waddr_d, raddr;
  logic [10:0]       p_off, freq_reg;
  logic [15:0]       phase;
  logic              ready, vsync_q, vs_edge, gen, we_d, neg_d, vis, vis_d1, wclk_q;
  logic [5:0]        lut_idx;
  logic [7:0]        lut_val;
  height_t           height, prof_q;
  height_t           mem [SCREEN_WIDTH];

  // Reset asserts immediately but releases on the clock to avoid a metastable exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign vs_edge = bus.vsync & ~vsync_q;
  assign gen     = (state == INIT) || (state == FILL);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      base     <= '0;
      p_off    <= '0;
      ready    <= 1'b0;
      vsync_q  <= 1'b0;
      freq_reg <= '0;
    end else begin
      vsync_q <= bus.vsync;
      if (bus.new_f) freq_reg <= bus.frequency;
      case (state)
        INIT: begin
          if (cnt == LAST_INIT) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (vs_edge) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL: begin
          if (cnt == LAST_FILL) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= base + SCROLL_A;
            p_off <= p_off + 11'(SCROLL);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Quadrants 1 and 3 walk the quarter-wave table backwards; bit 15 selects the negative half.
  assign lut_idx = phase[14] ? ~phase[13:8] : phase[13:8];
  assign waddr   = (state == FILL) ? base + cnt : cnt;

  sine_lut u_lut (
    .clock (clock),
    .idx   (lut_idx),
    .val   (lut_val)
  );

  // Address and sign trail the phase by one cycle to meet the registered ROM output.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      we_d    <= 1'b0;
      waddr_d <= '0;
      neg_d   <= 1'b0;
    end else begin
      we_d    <= gen;
      waddr_d <= waddr;
      neg_d   <= phase[15];
      if (gen) phase <= phase + {5'b00000, freq_reg};
    end
  end

  assign height = neg_d ? BASE_H + height_t'(lut_val) : BASE_H - height_t'(lut_val);

  always_ff @(posedge clock) begin
    if (we_d) mem[waddr_d] <= height;
  end

  assign vis = (bus.hcount < 11'(SCREEN_WIDTH)) && (bus.vcount < 10'(SCREEN_HEIGHT));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      raddr  <= '0;
      vis_d1 <= 1'b0;
      wclk_q <= 1'b0;
      prof_q <= '0;
    end else begin
      raddr  <= base + bus.hcount[ADDR_W-1:0];
      vis_d1 <= vis;
      wclk_q <= vis_d1;
      if (vis_d1) prof_q <= mem[raddr];
    end
  end

  assign bus.wave_prof  = prof_q;
  assign bus.wave_clk   = wclk_q;
  assign bus.p_offset   = p_off;
  assign bus.wave_ready = ready;

endmodule

// File: tb/tb_wave_stream.sv
// Directed bench for wave_stream: init fill, scroll, line timing, wrap, ignored edges, mid-fill reset.
module tb_wave_stream;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   prof, clk;

  always #5 clock = ~clock;

  wave_stream_if bus ();

  wave_stream #(.SCROLL(4), .BASELINE(384)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_col(input int x, output int p, output int c);
    bus.vcount = 10'd0;
    bus.hcount = 11'(x);
    tick();
    tick();
    p = int'(bus.wave_prof);
    c = int'(bus.wave_clk);
  endtask

  task automatic fill_edge();
    bus.vsync = 1'b1;
    repeat (7) tick();
    bus.vsync = 1'b0;
    tick();
  endtask

  // One full line; output seen after step c belongs to the hcount driven at step c-1.
  task automatic sweep(input int vc, input string tag, input int exp_first, input int exp_last);
    int clk_bad, prof_bad, first, last, h, exp_clk;
    clk_bad = 0; prof_bad = 0; first = -1; last = -1;
    bus.vcount = 10'(vc);
    for (int c = 0; c <= 1344; c++) begin
      bus.hcount = (c < 1344) ? 11'(c) : 11'd1100;
      tick();
      if (c > 0) begin
        h = c - 1;
        exp_clk = (h < 1024 && vc < 768) ? 1 : 0;
        if (int'(bus.wave_clk) != exp_clk) clk_bad++;
        if (bus.wave_clk) begin
          if (first < 0) first = h;
          last = h;
          if (bus.wave_prof != 10'd384) prof_bad++;
        end
      end
    end
    check_eq({tag, "_clk_bad"}, clk_bad, 0);
    check_eq({tag, "_prof_bad"}, prof_bad, 0);
    check_eq({tag, "_first_hi"}, first, exp_first);
    check_eq({tag, "_last_hi"}, last, exp_last);
  endtask

  initial begin
    reset         = 1'b0;
    bus.frequency = 11'd0;
    bus.new_f     = 1'b0;
    bus.vsync     = 1'b0;
    bus.hcount    = 11'd0;
    bus.vcount    = 10'd0;
    repeat (3) tick();
    check_eq("rst_prof", int'(bus.wave_prof), 0);
    check_eq("rst_clk", int'(bus.wave_clk), 0);
    check_eq("rst_poff", int'(bus.p_offset), 0);
    check_eq("rst_ready", int'(bus.wave_ready), 0);

    // Initial fill with a vsync pulse in the middle of it.
    reset = 1'b1;
    for (int i = 1; i <= 1027; i++) begin
      if (i == 500) bus.vsync = 1'b1;
      if (i == 510) bus.vsync = 1'b0;
      tick();
      if (i == 1020) check_eq("init_ready_early", int'(bus.wave_ready), 0);
    end
    check_eq("init_ready", int'(bus.wave_ready), 1);
    check_eq("init_poff", int'(bus.p_offset), 0);

    sweep(0, "line0", 0, 1023);
    sweep(768, "line768", -1, -1);

    // Latch frequency 1024, then drop the input so only the strobe matters.
    bus.frequency = 11'd1024;
    bus.new_f     = 1'b1;
    tick();
    bus.new_f     = 1'b0;
    bus.frequency = 11'd0;
    tick();

    // Vsync edge, then a second edge while FILL is still running.
    bus.vsync = 1'b1; tick();
    bus.vsync = 1'b0; tick();
    bus.vsync = 1'b1; tick();
    repeat (4) tick();
    bus.vsync = 1'b0; tick();
    repeat (2) tick();
    check_eq("fill1_poff", int'(bus.p_offset), 4);
    read_col(1019, prof, clk); check_eq("fill1_col1019", prof, 384);
    read_col(1020, prof, clk); check_eq("fill1_col1020", prof, 384);
    read_col(1021, prof, clk); check_eq("fill1_col1021", prof, 359);
    read_col(1022, prof, clk); check_eq("fill1_col1022", prof, 334);
    read_col(1023, prof, clk); check_eq("fill1_col1023", prof, 310);
    read_col(0, prof, clk);    check_eq("fill1_col0", prof, 384);

    // 511 more fills: 2048 samples total, base back to 0, p_offset wraps.
    for (int n = 2; n <= 512; n++) begin
      fill_edge();
      if (n == 511) check_eq("wrap_poff_2044", int'(bus.p_offset), 2044);
    end
    check_eq("wrap_poff_0", int'(bus.p_offset), 0);
    read_col(0, prof, clk);    check_eq("wrap_col0", prof, 384);
    read_col(4, prof, clk);    check_eq("wrap_col4", prof, 286);
    read_col(16, prof, clk);   check_eq("wrap_col16", prof, 129);
    read_col(40, prof, clk);   check_eq("wrap_col40", prof, 564);
    read_col(60, prof, clk);   check_eq("wrap_col60", prof, 476);
    read_col(511, prof, clk);  check_eq("wrap_col511", prof, 403);
    read_col(512, prof, clk);  check_eq("wrap_col512", prof, 384);
    read_col(1023, prof, clk); check_eq("wrap_col1023", prof, 403);
    check_eq("wrap_col1023_clk", clk, 1);

    // Off-screen: wave_clk drops, wave_prof holds the last visible value.
    bus.hcount = 11'd1100;
    repeat (3) tick();
    check_eq("hold_clk", int'(bus.wave_clk), 0);
    check_eq("hold_prof", int'(bus.wave_prof), 403);

    // Reset with the FILL counter at 2.
    bus.vsync = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_prof", int'(bus.wave_prof), 0);
    check_eq("midrst_clk", int'(bus.wave_clk), 0);
    check_eq("midrst_poff", int'(bus.p_offset), 0);
    check_eq("midrst_ready", int'(bus.wave_ready), 0);
    bus.vsync = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 1027; i++) begin
      tick();
      if (i == 1020) check_eq("reinit_ready_early", int'(bus.wave_ready), 0);
    end
    check_eq("reinit_ready", int'(bus.wave_ready), 1);
    check_eq("reinit_poff", int'(bus.p_offset), 0);
    read_col(16, prof, clk); check_eq("reinit_col16", prof, 384);
    read_col(40, prof, clk); check_eq("reinit_col40", prof, 384);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
